bank_isu_credit_arb: RTL and testbench

Round-robin issue arbiter and credit controller between the ISU's three per-channel request queues and the single ISU→SRAM-controller issue port. It grants at most one channel per cycle. A channel is only eligible while it holds a response credit toward the xbar. Each grant is stamped with a per-channel ROB number that the xbar uses to reorder returns. It sits inside the ISU, upstream of the `isu_sc_*` interface. It consumes the `xbar_isu_chN_credit` return pulses.

---
 rtl/bank_isu_credit_arb.sv | 109 ++++++++++
 tb/tb_bank_isu_credit_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_isu_credit_arb.sv
// Purpose: round-robin issue arbiter over three ISU channel queues, gated by per-channel xbar response credits, stamping each grant with a per-channel ROB number.
// Latency: zero-cycle grant (combinational from req_valid_i and registered state); credit/ROB/pointer state updates on the next clk_i edge.
// Backpressure: grant_ready_i low holds the presented channel and all state; a channel with zero credits is ineligible until a credit returns.
module bank_isu_credit_arb #(
   parameter int CREDIT_MAX = 4,
   parameter int ROB_W      = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       req_valid_i,
   output logic [2:0]       req_ready_o,
   output logic             grant_valid_o,
   input  logic             grant_ready_i,
   output logic [1:0]       grant_ch_o,
   output logic [ROB_W-1:0] grant_rob_num_o,
   input  logic [2:0]       xbar_credit_rtn_i,
   output logic [8:0]       credit_vec_o,
   output logic             credit_ovf_o
);

   localparam logic [2:0] LP_CMAX = 3'(CREDIT_MAX);

   logic [2:0][2:0]       r_credit;
   logic [2:0][ROB_W-1:0] r_rob;
   logic [1:0]            r_last;
   logic                  r_ovf;

   logic [2:0] w_elig;
   logic [1:0] w_ch;
   logic       w_any;
   logic       w_fire;

   // A channel may compete only while its head is valid and it still owns a response credit.
   always_comb begin
      w_elig = 3'b000;
      for (int c = 0; c < 3; c++) begin
         w_elig[c] = req_valid_i[c] & (r_credit[c] != 3'd0);
      end
   end

   // Search starts one past the last fired channel; falls back to 0 when nothing is eligible.
   always_comb begin
      w_ch = 2'd0;
      case (r_last)
         2'd0: begin
            if      (w_elig[1]) w_ch = 2'd1;
            else if (w_elig[2]) w_ch = 2'd2;
            else                w_ch = 2'd0;
         end
         2'd1: begin
            if      (w_elig[2]) w_ch = 2'd2;
            else if (w_elig[0]) w_ch = 2'd0;
            else if (w_elig[1]) w_ch = 2'd1;
            else                w_ch = 2'd0;
         end
         default: begin
            if      (w_elig[0]) w_ch = 2'd0;
            else if (w_elig[1]) w_ch = 2'd1;
            else if (w_elig[2]) w_ch = 2'd2;
            else                w_ch = 2'd0;
         end
      endcase
   end

   // Outputs are forced idle during reset so a pending issue is dropped cleanly.
   always_comb begin
      w_any           = (|w_elig) & ~rst_i;
      w_fire          = w_any & grant_ready_i;
      grant_valid_o   = w_any;
      grant_ch_o      = rst_i ? 2'd0 : w_ch;
      grant_rob_num_o = rst_i ? '0 : r_rob[w_ch];
      req_ready_o     = w_fire ? (3'b001 << w_ch) : 3'b000;
      credit_vec_o    = r_credit;
      credit_ovf_o    = r_ovf;
   end

   // Pointer, ROB counters and credit counters; a fire and a return on the same channel cancel out.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < 3; c++) begin
            r_credit[c] <= LP_CMAX;
            r_rob[c]    <= '0;
         end
         r_last <= 2'd2;
         r_ovf  <= 1'b0;
      end else begin
         if (w_fire) begin
            r_last <= w_ch;
         end
         for (int c = 0; c < 3; c++) begin
            if (req_ready_o[c]) begin
               r_rob[c] <= r_rob[c] + 1'b1;
            end
            case ({req_ready_o[c], xbar_credit_rtn_i[c]})
               2'b10: r_credit[c] <= r_credit[c] - 3'd1;
               2'b01: begin
                  if (r_credit[c] < LP_CMAX) begin
                     r_credit[c] <= r_credit[c] + 3'd1;
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bank_isu_credit_arb.sv
// Purpose: directed self-checking bench for bank_isu_credit_arb with hand-computed expectations.
// Latency: inputs driven #1 after posedge, outputs sampled before the next posedge.
// Backpressure: exercises stalls via grant_ready_i and credit exhaustion/return.
module tb_bank_isu_credit_arb;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [2:0] req_valid_i;
   logic [2:0] req_ready_o;
   logic       grant_valid_o;
   logic       grant_ready_i;
   logic [1:0] grant_ch_o;
   logic [2:0] grant_rob_num_o;
   logic [2:0] xbar_credit_rtn_i;
   logic [8:0] credit_vec_o;
   logic       credit_ovf_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   bank_isu_credit_arb #(.CREDIT_MAX(4), .ROB_W(3)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .grant_valid_o    (grant_valid_o),
      .grant_ready_i    (grant_ready_i),
      .grant_ch_o       (grant_ch_o),
      .grant_rob_num_o  (grant_rob_num_o),
      .xbar_credit_rtn_i(xbar_credit_rtn_i),
      .credit_vec_o     (credit_vec_o),
      .credit_ovf_o     (credit_ovf_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i             = 1'b1;
      req_valid_i       = 3'b000;
      grant_ready_i     = 1'b0;
      xbar_credit_rtn_i = 3'b000;
      cyc();
      rst_i = 1'b0;
      #1;
   endtask

   initial begin
      logic [1:0] exp_ch  [4];
      logic [2:0] exp_rob [4];
      exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd0};
      exp_rob = '{3'd0, 3'd0, 3'd0, 3'd1};

      // Reset with everything asserted: outputs idle, returns ignored.
      rst_i             = 1'b1;
      req_valid_i       = 3'b111;
      grant_ready_i     = 1'b1;
      xbar_credit_rtn_i = 3'b111;
      cyc();
      check("rst_gv",     32'(grant_valid_o),   32'd0);
      check("rst_rdy",    32'(req_ready_o),     32'd0);
      check("rst_ch",     32'(grant_ch_o),      32'd0);
      check("rst_rob",    32'(grant_rob_num_o), 32'd0);
      check("rst_credit", 32'(credit_vec_o),    32'o444);
      check("rst_ovf",    32'(credit_ovf_o),    32'd0);

      // Round robin with all channels requesting.
      rst_i             = 1'b0;
      xbar_credit_rtn_i = 3'b000;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rr_gv",  32'(grant_valid_o),   32'd1);
         check("rr_ch",  32'(grant_ch_o),      32'(exp_ch[i]));
         check("rr_rob", 32'(grant_rob_num_o), 32'(exp_rob[i]));
         check("rr_rdy", 32'(req_ready_o),     32'(3'b001 << exp_ch[i]));
         cyc();
      end
      check("rr_credit", 32'(credit_vec_o), 32'o332);
      // last=0: ch1 absent, so ch2 (rob 1) then ch0 (rob 2).
      req_valid_i = 3'b101;
      #1;
      check("rr_skip_ch",  32'(grant_ch_o),      32'd2);
      check("rr_skip_rob", 32'(grant_rob_num_o), 32'd1);
      cyc();
      check("rr_wrap_ch",  32'(grant_ch_o),      32'd0);
      check("rr_wrap_rob", 32'(grant_rob_num_o), 32'd2);

      // Credit exhaustion on ch1.
      do_reset();
      req_valid_i   = 3'b010;
      grant_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("ex_gv",  32'(grant_valid_o),   32'd1);
         check("ex_ch",  32'(grant_ch_o),      32'd1);
         check("ex_rob", 32'(grant_rob_num_o), 32'(i));
         cyc();
      end
      check("ex_gv_off", 32'(grant_valid_o),     32'd0);
      check("ex_rdy0",   32'(req_ready_o),       32'd0);
      check("ex_cr1",    32'(credit_vec_o[5:3]), 32'd0);
      cyc();
      check("ex_gv_off2", 32'(grant_valid_o), 32'd0);
      xbar_credit_rtn_i = 3'b010;
      #1;
      check("ex_rtn_same_cyc", 32'(grant_valid_o), 32'd0);
      cyc();
      xbar_credit_rtn_i = 3'b000;
      #1;
      check("ex_cr_back", 32'(credit_vec_o[5:3]), 32'd1);
      check("ex_gv_back", 32'(grant_valid_o),     32'd1);
      check("ex_rob4",    32'(grant_rob_num_o),   32'd4);
      cyc();
      check("ex_gv_again", 32'(grant_valid_o),     32'd0);
      check("ex_cr_zero",  32'(credit_vec_o[5:3]), 32'd0);

      // Stall on ch2.
      do_reset();
      req_valid_i   = 3'b100;
      grant_ready_i = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("st_gv",  32'(grant_valid_o),   32'd1);
         check("st_ch",  32'(grant_ch_o),      32'd2);
         check("st_rob", 32'(grant_rob_num_o), 32'd0);
         check("st_rdy", 32'(req_ready_o),     32'd0);
         cyc();
         check("st_credit", 32'(credit_vec_o), 32'o444);
      end
      grant_ready_i = 1'b1;
      #1;
      check("st_fire_rdy", 32'(req_ready_o), 32'b100);
      cyc();
      req_valid_i = 3'b000;
      #1;
      check("st_credit_after", 32'(credit_vec_o), 32'o344);

      // Simultaneous fire and return on ch0 at full credit.
      do_reset();
      req_valid_i       = 3'b001;
      grant_ready_i     = 1'b1;
      xbar_credit_rtn_i = 3'b001;
      #1;
      check("sim_rdy", 32'(req_ready_o), 32'b001);
      cyc();
      check("sim_credit", 32'(credit_vec_o), 32'o444);
      check("sim_ovf",    32'(credit_ovf_o), 32'd0);
      req_valid_i = 3'b000;
      cyc();
      xbar_credit_rtn_i = 3'b000;
      check("ovf_set",    32'(credit_ovf_o), 32'd1);
      check("ovf_credit", 32'(credit_vec_o), 32'o444);
      cyc();
      check("ovf_sticky", 32'(credit_ovf_o), 32'd1);
      do_reset();
      check("ovf_cleared", 32'(credit_ovf_o), 32'd0);

      // ROB wrap on ch0 with a credit returned every cycle.
      req_valid_i       = 3'b001;
      grant_ready_i     = 1'b1;
      xbar_credit_rtn_i = 3'b001;
      #1;
      for (int i = 0; i < 9; i++) begin
         check("wrap_rob", 32'(grant_rob_num_o), 32'(i % 8));
         cyc();
      end
      check("wrap_credit", 32'(credit_vec_o), 32'o444);
      check("wrap_ovf",    32'(credit_ovf_o), 32'd0);

      // Reset mid-operation with ch1 at credit 1, rob 5.
      do_reset();
      req_valid_i       = 3'b010;
      grant_ready_i     = 1'b1;
      xbar_credit_rtn_i = 3'b010;
      cyc();
      cyc();
      xbar_credit_rtn_i = 3'b000;
      cyc();
      cyc();
      cyc();
      check("mid_credit", 32'(credit_vec_o),    32'o414);
      check("mid_rob",    32'(grant_rob_num_o), 32'd5);
      rst_i       = 1'b1;
      req_valid_i = 3'b111;
      #1;
      check("mid_rst_gv",  32'(grant_valid_o), 32'd0);
      check("mid_rst_rdy", 32'(req_ready_o),   32'd0);
      cyc();
      check("mid_rst_credit", 32'(credit_vec_o), 32'o444);
      rst_i = 1'b0;
      #1;
      check("mid_post_ch",  32'(grant_ch_o),      32'd0);
      check("mid_post_rob", 32'(grant_rob_num_o), 32'd0);
      cyc();
      check("mid_post_ch1",  32'(grant_ch_o),      32'd1);
      check("mid_post_rob1", 32'(grant_rob_num_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
